// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory slave. A request is accepted in
// IDLE, counts down in WAIT and completes with a one-cycle ready pulse in DONE.
// The storage access happens on the edge that enters DONE. Misaligned or
// simultaneous read/write requests are suppressed and flagged with error.
module mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ready,
  output logic        busy,
  output logic        error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   din_q, din_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic [31:0]   dout_q, dout_d;

  logic          enter_done;
  logic          mem_we;
  logic          mem_re;
  logic          req_err;

  // Storage is never reset so it can map onto block RAM.
  logic [31:0]   mem [DEPTH];

  // Address bits above the word index are deliberately ignored (wrap-around).
  logic          unused_addr_bits;
  assign unused_addr_bits = ^addr[31:AW+2];

  assign req_err = (addr[1:0] != 2'b00) || (mem_read && mem_write);

  // Next-state and request-latching logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    din_d   = din_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          idx_d   = addr[AW+1:2];
          din_d   = din;
          rd_d    = mem_read;
          wr_d    = mem_write;
          err_d   = req_err;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY > 1) ? WAIT : DONE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Storage access on the edge entering DONE; the *_d request fields already
  // hold the right values both at acceptance (LATENCY=1) and later.
  always_comb begin
    enter_done = (state_d == DONE) && (state_q != DONE);
    mem_we     = reset && enter_done && wr_d && !err_d;
    mem_re     = enter_done && rd_d && !err_d;
    dout_d     = mem_re ? mem[idx_d] : dout_q;
  end

  // Control and read-data registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      din_q   <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Storage write port; gated by reset so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_d] <= din_d;
    end
  end

  assign dout  = dout_q;
  assign ready = (state_q == DONE);
  assign busy  = (state_q != IDLE);
  assign error = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: scoreboard of expected responses for the
// LATENCY=2 instance, plus a short directed check of a LATENCY=1 instance.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_read, mem_write;
  logic [31:0] addr, din, dout;
  logic        ready, busy, error;

  logic        reset_1, mem_read_1, mem_write_1;
  logic [31:0] addr_1, din_1, dout_1;
  logic        ready_1, busy_1, error_1;

  mem_responder #(.LATENCY(LAT), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .din(din), .dout(dout), .ready(ready), .busy(busy), .error(error)
  );

  mem_responder #(.LATENCY(1), .DEPTH(256)) dut1 (
    .clk(clk), .reset(reset_1), .mem_read(mem_read_1), .mem_write(mem_write_1),
    .addr(addr_1), .din(din_1), .dout(dout_1), .ready(ready_1), .busy(busy_1),
    .error(error_1)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] dout;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem[int];
  logic [31:0] model_dout = 32'h0;

  // Model one accepted request and queue its expected response.
  task automatic expect_req(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [31:0] d);
    exp_t e;
    int   idx;
    idx   = int'((a >> 2) & 32'hFF);
    e.err = (a[1:0] != 2'b00) || (rd && wr);
    if (!e.err && wr) model_mem[idx] = d;
    if (!e.err && rd) model_dout = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
    e.dout = model_dout;
    sb.push_back(e);
  endtask

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit hold);
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    din       = d;
    expect_req(rd, wr, a, d);
    @(posedge clk);
    if (!hold) begin
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  endtask

  // Called right after the acceptance edge; waits for ready and checks it.
  task automatic wait_resp(input string name, input bit toggle_rd);
    int   lat = 0;
    bit   seen = 0;
    exp_t e;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ready) seen = 1;
      else if (lat == 1 && toggle_rd) mem_read = 1'b1;
    end
    if (toggle_rd) mem_read = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: ready not seen within %0d cycles", name, lat);
    end
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT);
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    total++;
    if (error !== e.err) begin
      bad++;
      $display("FAIL %s error: got %b expected %b", name, error, e.err);
    end
    total++;
    if (dout !== e.dout) begin
      bad++;
      $display("FAIL %s dout: got %h expected %h", name, dout, e.dout);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL %s busy_in_done: got %b expected 1", name, busy);
    end
    $display("resp %s lat=%0d err=%b dout=%h", name, lat, error, dout);
  endtask

  task automatic test_reset();
    reset = 1'b1; reset_1 = 1'b1;
    mem_read = 0; mem_write = 0; addr = 0; din = 0;
    mem_read_1 = 0; mem_write_1 = 0; addr_1 = 0; din_1 = 0;
    #2;
    reset = 1'b0; reset_1 = 1'b0;
    #2;
    total++;
    if ({busy, ready, error} !== 3'b000 || dout !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: busy=%b ready=%b error=%b dout=%h expected 0", busy, ready, error, dout);
    end
    total++;
    if ({busy_1, ready_1, error_1} !== 3'b000 || dout_1 !== 32'h0) begin
      bad++;
      $display("FAIL reset_state_lat1: busy=%b ready=%b error=%b dout=%h expected 0", busy_1, ready_1, error_1, dout_1);
    end
    $display("reset checked");
    @(negedge clk);
    reset = 1'b1; reset_1 = 1'b1;
  endtask

  task automatic test_write_read();
    issue(0, 1, 32'h10, 32'hDEADBEEF, 0);
    wait_resp("wr_0x10", 0);
    issue(1, 0, 32'h10, 32'h0, 0);
    wait_resp("rd_0x10", 0);
  endtask

  task automatic test_misaligned();
    issue(0, 1, 32'h400, 32'h13579BDF, 0);
    wait_resp("wr_0x400", 0);
    issue(0, 1, 32'h402, 32'hAAAA5555, 0);
    wait_resp("wr_0x402_misaligned", 0);
    issue(1, 0, 32'h400, 32'h0, 0);
    wait_resp("rd_0x400_prior", 0);
  endtask

  task automatic test_wrap();
    issue(0, 1, 32'h400, 32'h00000001, 0);
    wait_resp("wr_0x400_wrap", 0);
    issue(1, 0, 32'h000, 32'h0, 0);
    wait_resp("rd_0x000_wrap", 0);
  endtask

  task automatic test_both();
    issue(0, 1, 32'h8, 32'h0BADF00D, 0);
    wait_resp("wr_0x8", 0);
    issue(1, 0, 32'h8, 32'h0, 0);
    wait_resp("rd_0x8", 0);
    issue(1, 1, 32'h8, 32'hFFFFFFFF, 0);
    wait_resp("both_0x8", 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || ready !== 1'b0) begin
        bad++;
        $display("FAIL no_extra_accept[%0d]: busy=%b ready=%b expected 0", i, busy, ready);
      end
    end
    issue(1, 0, 32'h8, 32'h0, 0);
    wait_resp("rd_0x8_after_both", 0);
  endtask

  task automatic test_back_to_back();
    issue(0, 1, 32'h30, 32'h5A5A0001, 0);
    wait_resp("wr_0x30", 0);
    issue(1, 0, 32'h30, 32'h0, 1);
    wait_resp("rd_0x30_held", 0);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_done: busy=%b expected 0", busy);
    end
    expect_req(1, 0, 32'h30, 32'h0);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    wait_resp("rd_0x30_reaccept", 0);
  endtask

  task automatic test_reset_abort();
    bit ready_seen = 0;
    issue(0, 1, 32'h20, 32'h11111111, 0);
    wait_resp("wr_0x20", 0);
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h20; din = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_in_wait: busy=%b expected 1", busy);
    end
    reset = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || ready !== 1'b0 || error !== 1'b0 || dout !== 32'h0) begin
      bad++;
      $display("FAIL abort_reset_state: busy=%b ready=%b error=%b dout=%h expected 0", busy, ready, error, dout);
    end
    model_dout = 32'h0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ready) ready_seen = 1;
    end
    total++;
    if (ready_seen) begin
      bad++;
      $display("FAIL abort_no_ready: ready seen=1 expected 0");
    end
    issue(1, 0, 32'h20, 32'h0, 0);
    wait_resp("rd_0x20_after_abort", 0);
  endtask

  task automatic test_lat1();
    @(negedge clk);
    mem_write_1 = 1'b1; addr_1 = 32'h0; din_1 = 32'h12345678;
    @(posedge clk);
    #1;
    mem_write_1 = 1'b0;
    @(negedge clk);
    total++;
    if (ready_1 !== 1'b1 || busy_1 !== 1'b1 || error_1 !== 1'b0) begin
      bad++;
      $display("FAIL lat1_write_resp: ready=%b busy=%b error=%b expected 1 1 0", ready_1, busy_1, error_1);
    end
    @(negedge clk);
    mem_read_1 = 1'b1; addr_1 = 32'h0;
    total++;
    if (busy_1 !== 1'b0) begin
      bad++;
      $display("FAIL lat1_busy_one_cycle: busy=%b expected 0", busy_1);
    end
    @(posedge clk);
    #1;
    mem_read_1 = 1'b0;
    @(negedge clk);
    total++;
    if (ready_1 !== 1'b1 || dout_1 !== 32'h12345678) begin
      bad++;
      $display("FAIL lat1_read_resp: ready=%b dout=%h expected 1 12345678", ready_1, dout_1);
    end
    @(negedge clk);
    total++;
    if (busy_1 !== 1'b0 || ready_1 !== 1'b0) begin
      bad++;
      $display("FAIL lat1_idle: busy=%b ready=%b expected 0 0", busy_1, ready_1);
    end
    $display("resp lat1 dout=%h", dout_1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_wrap();
    test_both();
    test_back_to_back();
    test_reset_abort();
    test_lat1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
